// File: rtl/crc_lfsr_engine_pkg.sv
// Shared types and bit-level helpers for the serial CRC engine.
// Both helpers work on 32-bit containers, using only the low w bits.
package crc_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, WAIT, DONE} state_t;

   // One Galois LFSR step: feedback is the register MSB XOR the incoming bit.
   function automatic logic [31:0] crc_step(input logic [31:0] lfsr,
                                            input logic        b,
                                            input logic [31:0] poly,
                                            input int          w);
      logic [31:0] mask;
      logic        fb;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      fb   = lfsr[5'(w - 1)] ^ b;
      return ((lfsr << 1) ^ (fb ? poly : 32'd0)) & mask;
   endfunction

   function automatic logic [31:0] bit_reverse(input logic [31:0] v,
                                               input int          w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < w) r[5'(i)] = v[5'(w - 1 - i)];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc_lfsr_engine_if.sv
// Word-stream input and held-result output of the CRC engine.
// Handshakes: a transfer happens on a rising clk edge where valid and ready are both 1; valid is held until then.
interface crc_lfsr_engine_if #(
   parameter int DATA_W = 10,
   parameter int CRC_W  = 9
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              chk_mode;
   logic              out_valid;
   logic              out_ready;
   logic [CRC_W-1:0]  crc_out;
   logic              crc_ok;
   logic              busy;

   modport slave (
      input  in_valid, in_data, in_last, chk_mode, out_ready,
      output in_ready, out_valid, crc_out, crc_ok, busy
   );

   modport master (
      output in_valid, in_data, in_last, chk_mode, out_ready,
      input  in_ready, out_valid, crc_out, crc_ok, busy
   );
endinterface

// File: rtl/crc_lfsr_engine_core.sv
// LFSR register of the CRC engine: load to INIT, or advance one serial bit.
// o_lfsr_next is the value the register takes on a shift, so the engine can capture the final CRC on the same edge.
module crc_lfsr_core
   import crc_pkg::*;
#(
   parameter int             CRC_W = 9,
   parameter logic [CRC_W-1:0] POLY  = 9'h003,
   parameter logic [CRC_W-1:0] INIT  = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load_init,
   input  logic             i_shift_en,
   input  logic             i_bit,
   output logic [CRC_W-1:0] o_lfsr,
   output logic [CRC_W-1:0] o_lfsr_next
);
   logic [CRC_W-1:0] r_lfsr;

   assign o_lfsr_next = CRC_W'(crc_step(32'(r_lfsr), i_bit, 32'(POLY), CRC_W));
   assign o_lfsr      = r_lfsr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lfsr <= INIT;
      end else if (i_load_init) begin
         r_lfsr <= INIT;
      end else if (i_shift_en) begin
         r_lfsr <= o_lfsr_next;
      end
   end
endmodule

// File: rtl/crc_lfsr_engine.sv
// Bit-serial CRC generator/checker: words in over a handshake, one bit per clk, result held at frame end.
// Optional macro CRC_REFLECT_EN: shift words LSB-first and bit-reverse crc_out (reflected CRCs).
module crc_lfsr_engine
   import crc_pkg::*;
#(
   parameter int               DATA_W  = 10,
   parameter int               CRC_W   = 9,
   parameter logic [CRC_W-1:0] POLY    = 9'h003,
   parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b0}},
   parameter logic [CRC_W-1:0] XOROUT  = {CRC_W{1'b0}},
   parameter logic [CRC_W-1:0] RESIDUE = {CRC_W{1'b0}}
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clear,
   crc_lfsr_engine_if.slave    bus,
   output state_t              o_dbg_state
);
   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t            r_state, w_state_next;
   logic [DATA_W-1:0] r_word;
   logic              r_last;
   logic              r_chk;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_out_valid;
   logic [CRC_W-1:0]  r_crc_out;
   logic              r_crc_ok;

   logic              w_in_ready;
   logic              w_accept;
   logic              w_load_init;
   logic              w_shift_en;
   logic              w_enter_done;
   logic              w_out_accept;
   logic              w_cnt_end;
   logic              w_bit;
   logic [CRC_W-1:0]  w_lfsr;
   logic [CRC_W-1:0]  w_lfsr_next;
   logic [CRC_W-1:0]  w_crc_final;

   assign w_cnt_end = (r_cnt == CNT_W'(DATA_W - 1));

`ifdef CRC_REFLECT_EN
   assign w_bit       = r_word[0];
   assign w_crc_final = CRC_W'(bit_reverse(32'(w_lfsr_next), CRC_W)) ^ XOROUT;
`else
   assign w_bit       = r_word[DATA_W-1];
   assign w_crc_final = w_lfsr_next ^ XOROUT;
`endif

   crc_lfsr_core #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .INIT  (INIT)
   ) u_core (
      .clk         (clk),
      .reset       (reset),
      .i_load_init (w_load_init),
      .i_shift_en  (w_shift_en),
      .i_bit       (w_bit),
      .o_lfsr      (w_lfsr),
      .o_lfsr_next (w_lfsr_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_accept     = 1'b0;
      w_load_init  = 1'b0;
      w_shift_en   = 1'b0;
      w_enter_done = 1'b0;
      w_out_accept = 1'b0;
      case (r_state)
         IDLE: begin
            w_in_ready  = 1'b1;
            w_load_init = 1'b1;
            if (bus.in_valid) begin
               w_accept     = 1'b1;
               w_state_next = SHIFT;
            end
         end
         SHIFT: begin
            w_shift_en = 1'b1;
            if (w_cnt_end) begin
               w_enter_done = r_last;
               w_state_next = r_last ? DONE : WAIT;
            end
         end
         WAIT: begin
            w_in_ready = 1'b1;
            if (bus.in_valid) begin
               w_accept     = 1'b1;
               w_state_next = SHIFT;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               w_out_accept = 1'b1;
               w_load_init  = 1'b1;
               w_state_next = IDLE;
            end
         end
         default: w_state_next = IDLE;
      endcase
      // Abort outranks any handshake or shift landing in the same cycle.
      if (clear) begin
         w_state_next = IDLE;
         w_load_init  = 1'b1;
         w_accept     = 1'b0;
         w_shift_en   = 1'b0;
         w_enter_done = 1'b0;
         w_out_accept = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_word      <= '0;
         r_last      <= 1'b0;
         r_chk       <= 1'b0;
         r_cnt       <= '0;
         r_out_valid <= 1'b0;
         r_crc_out   <= '0;
         r_crc_ok    <= 1'b0;
      end else begin
         if (w_accept) begin
            r_word <= bus.in_data;
            r_last <= bus.in_last;
            r_cnt  <= '0;
            if (r_state == IDLE) r_chk <= bus.chk_mode;
         end else if (w_shift_en) begin
`ifdef CRC_REFLECT_EN
            r_word <= r_word >> 1;
`else
            r_word <= r_word << 1;
`endif
            r_cnt  <= w_cnt_end ? '0 : r_cnt + CNT_W'(1);
         end
         if (clear || w_out_accept) begin
            r_out_valid <= 1'b0;
         end else if (w_enter_done) begin
            r_out_valid <= 1'b1;
            r_crc_out   <= w_crc_final;
            r_crc_ok    <= r_chk & (w_lfsr_next == RESIDUE);
         end
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.crc_out   = r_crc_out;
   assign bus.crc_ok    = r_crc_ok;
   assign bus.busy      = (r_state != IDLE);
   assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_crc_lfsr_engine.sv
// Bench for crc_lfsr_engine: a CRC-8 and a CRC-16/CCITT instance share one byte stream,
// each result is checked against a byte-wise polynomial-division model through a scoreboard.
module tb_crc_lfsr_engine;
   import crc_pkg::*;

   typedef logic [7:0] byte_q_t[$];

   logic       clk = 1'b0;
   logic       reset;
   logic       clear;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_last;
   logic       chk_mode;
   logic       out_ready;
   state_t     st8, st16;

   int         cyc = 0;
   int         checks = 0;
   int         failures = 0;
   int         hs_cyc = 0;
   bit         hold_ready = 1'b0;

   logic [8:0]  exp8_q[$];
   logic [16:0] exp16_q[$];
   logic [7:0]  last_crc8;
   logic        last_ok8;
   logic [15:0] last_crc16;

   crc_lfsr_engine_if #(.DATA_W(8), .CRC_W(8))  if8();
   crc_lfsr_engine_if #(.DATA_W(8), .CRC_W(16)) if16();

   assign if8.in_valid   = in_valid;
   assign if8.in_data    = in_data;
   assign if8.in_last    = in_last;
   assign if8.chk_mode   = chk_mode;
   assign if8.out_ready  = out_ready;
   assign if16.in_valid  = in_valid;
   assign if16.in_data   = in_data;
   assign if16.in_last   = in_last;
   assign if16.chk_mode  = chk_mode;
   assign if16.out_ready = out_ready;

   crc_lfsr_engine #(
      .DATA_W(8), .CRC_W(8), .POLY(8'h07), .INIT(8'h00), .XOROUT(8'h00), .RESIDUE(8'h00)
   ) dut8 (
      .clk(clk), .reset(reset), .clear(clear), .bus(if8), .o_dbg_state(st8)
   );

   crc_lfsr_engine #(
      .DATA_W(8), .CRC_W(16), .POLY(16'h1021), .INIT(16'hFFFF), .XOROUT(16'h0000), .RESIDUE(16'h0000)
   ) dut16 (
      .clk(clk), .reset(reset), .clear(clear), .bus(if16), .o_dbg_state(st16)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   // ---------------- reference model ----------------
   function automatic logic [7:0] rev8(input logic [7:0] b);
      logic [7:0] r;
      for (int k = 0; k < 8; k++) r[k] = b[7-k];
      return r;
   endfunction

   // Polynomial division of the message, one whole byte folded in at a time.
   function automatic logic [31:0] model_reg(input byte_q_t msg, input int w,
                                             input logic [31:0] poly, input logic [31:0] init);
      logic [31:0] r, mask;
      logic [7:0]  b;
      mask = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      r = init;
      foreach (msg[i]) begin
         b = msg[i];
`ifdef CRC_REFLECT_EN
         b = rev8(b);
`endif
         r = r ^ (32'(b) << (w - 8));
         for (int k = 0; k < 8; k++) r = r[w-1] ? ((r << 1) ^ poly) : (r << 1);
         r = r & mask;
      end
      return r;
   endfunction

   function automatic logic [31:0] model_out(input logic [31:0] r, input int w);
`ifdef CRC_REFLECT_EN
      logic [31:0] o;
      o = '0;
      for (int k = 0; k < w; k++) o[k] = r[w-1-k];
      return o;
`else
      return r;
`endif
   endfunction

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      checks++;
      failures++;
      $display("FAIL %s", name);
   endtask

   // ---------------- driver tasks ----------------
   task automatic send_word(input logic [7:0] data, input bit last, input bit chk);
      int budget;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      chk_mode = chk;
      budget   = 0;
      while (!if8.in_ready && budget <= 200) begin
         @(negedge clk);
         budget++;
      end
      if (budget > 200) fail_now("in_ready timeout");
      hs_cyc = cyc;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
   endtask

   task automatic push_expect(input byte_q_t msg, input bit chk);
      logic [31:0] r8, r16, o8, o16;
      r8  = model_reg(msg, 8, 32'h07, 32'h00);
      r16 = model_reg(msg, 16, 32'h1021, 32'hFFFF);
      o8  = model_out(r8, 8);
      o16 = model_out(r16, 16);
      exp8_q.push_back({chk && (r8 == 32'h0), o8[7:0]});
      exp16_q.push_back({chk && (r16 == 32'h0), o16[15:0]});
   endtask

   task automatic send_frame(input byte_q_t msg, input bit chk);
      push_expect(msg, chk);
      foreach (msg[i]) send_word(msg[i], (i == msg.size() - 1), chk);
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      while ((exp8_q.size() != 0 || exp16_q.size() != 0 || if8.out_valid) && budget < 500) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 500) fail_now("drain timeout");
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [8:0]  e8;
      logic [16:0] e16;
      bit          prev8, prev16;
      prev8  = 1'b0;
      prev16 = 1'b0;
      out_ready = 1'b0;
      forever begin
         @(negedge clk);
         out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
         if (reset) begin
            prev8  = 1'b0;
            prev16 = 1'b0;
         end else begin
            if (if8.out_valid && !prev8)   check("dut8 latency", cyc - hs_cyc, 9);
            if (if16.out_valid && !prev16) check("dut16 latency", cyc - hs_cyc, 9);
            prev8  = if8.out_valid;
            prev16 = if16.out_valid;
            if (if8.out_valid && out_ready) begin
               if (exp8_q.size() == 0) fail_now("dut8 unexpected result");
               else begin
                  e8 = exp8_q.pop_front();
                  check("dut8 crc_out", 32'(if8.crc_out), 32'(e8[7:0]));
                  check("dut8 crc_ok", 32'(if8.crc_ok), 32'(e8[8]));
                  last_crc8 = if8.crc_out;
                  last_ok8  = if8.crc_ok;
               end
            end
            if (if16.out_valid && out_ready) begin
               if (exp16_q.size() == 0) fail_now("dut16 unexpected result");
               else begin
                  e16 = exp16_q.pop_front();
                  check("dut16 crc_out", 32'(if16.crc_out), 32'(e16[15:0]));
                  check("dut16 crc_ok", 32'(if16.crc_ok), 32'(e16[16]));
                  last_crc16 = if16.crc_out;
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      byte_q_t msg;
      byte_q_t m4;
      int      budget;
      reset    = 1'b1;
      clear    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;
      chk_mode = 1'b0;
      for (int i = 0; i < 9; i++) msg.push_back(8'h31 + 8'(i));

      repeat (3) @(negedge clk);
      check("reset in_ready", 32'(if8.in_ready), 1);
      check("reset out_valid", 32'(if8.out_valid), 0);
      check("reset busy", 32'(if8.busy), 0);
      check("reset crc_out", 32'(if8.crc_out), 0);
      check("reset crc_ok", 32'(if8.crc_ok), 0);
      check("reset state", 32'(st8), 32'(IDLE));
      reset = 1'b0;
      @(negedge clk);

      // Standard check strings for CRC-8 and CRC-16/CCITT-FALSE
      send_frame(msg, 1'b0);
      drain();
`ifndef CRC_REFLECT_EN
      check("crc8 123456789", 32'(last_crc8), 32'hF4);
      check("crc16 123456789", 32'(last_crc16), 32'h29B1);
`endif

      // Check mode with good and corrupted trailing CRC
      msg.push_back(8'hF4);
      send_frame(msg, 1'b1);
      drain();
`ifndef CRC_REFLECT_EN
      check("check good crc_ok", 32'(last_ok8), 1);
`endif
      msg[9] = 8'hF5;
      send_frame(msg, 1'b1);
      drain();
`ifndef CRC_REFLECT_EN
      check("check bad crc_ok", 32'(last_ok8), 0);
`endif
      void'(msg.pop_back());

      // Result held under back-pressure
      hold_ready = 1'b1;
      send_frame(msg, 1'b0);
      budget = 0;
      while (!if8.out_valid && budget < 100) begin
         @(negedge clk);
         budget++;
      end
      if (budget >= 100) fail_now("out_valid timeout");
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("held out_valid", 32'(if8.out_valid), 1);
         check("held crc_out", 32'(if8.crc_out), 32'(exp8_q[0][7:0]));
         check("held crc_ok", 32'(if8.crc_ok), 32'(exp8_q[0][8]));
         check("held in_ready", 32'(if8.in_ready), 0);
      end
      hold_ready = 1'b0;
      drain();
      send_frame(msg, 1'b0);
      drain();
`ifndef CRC_REFLECT_EN
      check("after hold crc8", 32'(last_crc8), 32'hF4);
`endif

      // Abort with clear after four words, then a clean frame
      for (int i = 0; i < 4; i++) m4.push_back(8'h31 + 8'(i));
      foreach (m4[i]) send_word(m4[i], 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      check("clear busy", 32'(if8.busy), 0);
      check("clear out_valid", 32'(if8.out_valid), 0);
      send_frame(msg, 1'b0);
      drain();
`ifndef CRC_REFLECT_EN
      check("after clear crc8", 32'(last_crc8), 32'hF4);
      check("after clear crc16", 32'(last_crc16), 32'h29B1);
`endif

      // Asynchronous reset in the middle of a shift
      send_word(8'h31, 1'b0, 1'b0);
      send_word(8'h32, 1'b0, 1'b0);
      @(negedge clk);
      check("pre-reset busy", 32'(if8.busy), 1);
      #2;
      reset = 1'b1;
      #1;
      check("async reset out_valid", 32'(if8.out_valid), 0);
      check("async reset busy", 32'(if8.busy), 0);
      check("async reset crc8", 32'(if8.crc_out), 0);
      check("async reset crc16", 32'(if16.crc_out), 0);
      check("async reset in_ready", 32'(if8.in_ready), 1);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Single-word frames
      send_frame('{8'h00}, 1'b0);
      drain();
`ifndef CRC_REFLECT_EN
      check("single 0x00 crc8", 32'(last_crc8), 32'h00);
`endif
      send_frame('{8'h01}, 1'b0);
      drain();
`ifndef CRC_REFLECT_EN
      check("single 0x01 crc8", 32'(last_crc8), 32'h07);
`endif

      // Random frames with random lengths, modes and back-pressure
      for (int f = 0; f < 30; f++) begin
         byte_q_t rm;
         int      len;
         len = $urandom_range(1, 5);
         for (int i = 0; i < len; i++) rm.push_back(8'($urandom));
         send_frame(rm, 1'($urandom_range(0, 1)));
      end
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/crc_lfsr_engine.md
Name: crc_lfsr_engine

Overview:
Parametrised bit-serial CRC engine built on a Galois LFSR, for generating and checking frame CRCs.
- Accepts DATA_W-bit words over a valid/ready handshake and serialises each word MSB-first, one bit per clk.
- Frames are delimited by in_last. At frame end it presents the CRC, or a pass/fail check result, on a held output handshake.
- Sits between a word-stream source and the framer/deframer. It supersedes the fixed 10-bit/9-bit serial CRC block.

Parameters:
DATA_W, 10, input word width in bits (>=1)
CRC_W, 9, CRC register width (2..32)
POLY, 9'h003, generator polynomial without the implicit x^CRC_W term
INIT, {CRC_W{1'b0}}, register value loaded at frame start
XOROUT, {CRC_W{1'b0}}, value XORed onto the register to form crc_out
RESIDUE, {CRC_W{1'b0}}, expected final register value in check mode

Ports:
clk  in  1  clock
reset  in  1  reset, asynchronous, active-high
clear  in  1  synchronous abort; returns to IDLE and discards the frame
in_valid  in  1  input word valid
in_ready  out  1  engine can accept a word
in_data  in  DATA_W  input word, MSB shifted first
in_last  in  1  word is the last of the frame
chk_mode  in  1  0=generate, 1=check; sampled with the first word of a frame
out_valid  out  1  result valid, held until accepted
out_ready  in  1  consumer accepts the result
crc_out  out  CRC_W  final register XOR XOROUT
crc_ok  out  1  check mode: final register == RESIDUE; 0 in generate mode
busy  out  1  a frame is in progress (state != IDLE)

Behaviour:
- Reset values: state=IDLE, LFSR=INIT, out_valid=0, crc_out=0, crc_ok=0, busy=0, bit counter=0.
- in_ready is decoded from state: 1 in IDLE and WAIT, 0 otherwise. It is therefore 1 during and after reset.
- Bit update, with b the current serial bit:
  - fb = lfsr[CRC_W-1]^b
  - lfsr <= {lfsr[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0)
- States:
  - IDLE: LFSR held at INIT. On in_valid&in_ready: latch word, in_last and chk_mode; go to SHIFT.
  - SHIFT: one bit per cycle for DATA_W cycles; counter runs 0..DATA_W-1. After the last bit, go to DONE if the latched last=1, else WAIT.
  - WAIT: LFSR retained. On handshake, latch the word and go to SHIFT. chk_mode is not re-sampled.
  - DONE: out_valid=1; crc_out and crc_ok are registered on entry and held stable. On out_ready, set out_valid=0, reload LFSR to INIT and go to IDLE.
- Latency: word accepted at cycle t is shifted in cycles t+1..t+DATA_W. For a last word, out_valid rises at t+DATA_W+1.
- Throughput: one word per DATA_W+1 cycles. There is no acceptance during SHIFT.
- Boundary conditions:
  - Single-word frame (in_last on the first word) is legal.
  - in_valid while in_ready=0 is ignored, with no loss. The source must hold the word until it is accepted.
  - clear beats every other event in the same cycle: it forces IDLE, LFSR=INIT and out_valid=0.
  - Asynchronous reset mid-frame zeros all outputs immediately.
  - out_ready while out_valid=0 has no effect.

Optional Feature:
CRC_REFLECT_EN
- Defined: each word is shifted LSB-first, and crc_out is the bit-reversed register XOR XOROUT. This gives reflected CRCs such as CRC-32.
- Undefined: MSB-first shifting and non-reflected output exactly as above.
- crc_ok always compares the unreflected register against RESIDUE.

Decomposition:
- Package crc_pkg holds:
  - state enum {IDLE,SHIFT,WAIT,DONE};
  - the function crc_step(lfsr,bit,poly);
  - the function bit_reverse.
- One sub-module is natural: crc_lfsr_core. It holds the LFSR register with load_init, shift_en and serial bit inputs.
- The FSM, counter and handshake live in crc_lfsr_engine.

Test Plan:
1. DATA_W=8, CRC_W=8, POLY=8'h07, INIT=0. Send words 0x31..0x39, in_last on 0x39 -> crc_out=0xF4 and out_valid exactly 9 cycles after the 0x39 handshake.
2. CRC_W=16, POLY=16'h1021, INIT=16'hFFFF. Same message -> crc_out=0x29B1.
3. CRC-8 check mode, message 0x31..0x39 then 0xF4 (last) -> crc_ok=1. Repeat with 0xF5 -> crc_ok=0.
4. Hold out_ready low for 5 cycles in DONE -> out_valid, crc_out and crc_ok stable; in_ready=0. The next frame starts from INIT and again yields 0xF4.
5. Pulse clear after the 4th word; then send "123456789" -> crc_out=0xF4. Assert reset mid-SHIFT -> out_valid, busy and crc_out are 0 without a clock edge.
6. CRC-8 single-word frames: 0x00 -> crc_out=0x00; 0x01 -> 0x07. With CRC_REFLECT_EN, verify crc_out is the bit reversal of the register.
